// File: rtl/lorenz_pkg.sv
// Shared widths, 7.20 fixed-point constants and types for the Lorenz integrator.
package lorenz_pkg;
  localparam int WIDTH    = 27;
  localparam int FRAC     = 20;
  localparam int DT_SHIFT = 8;
  localparam int WIDE_W   = 2 * WIDTH - FRAC;
  localparam int SUM_W    = WIDE_W + 2;

  typedef logic signed [WIDTH-1:0]  fx_t;
  typedef logic signed [WIDE_W-1:0] fx_wide_t;

  localparam fx_t SIGMA = 27'sd10485760;
  localparam fx_t RHO   = 27'sd29360128;
  localparam fx_t BETA  = 27'sd2796203;
  localparam fx_t X0    = -27'sd1048576;
  localparam fx_t Y0    = 27'sd104858;
  localparam fx_t Z0    = 27'sd26214400;
endpackage

// File: rtl/lorenz_euler_integrator_fx_mult.sv
// Signed fixed-point multiply: full-width product, floor shift by FRAC, kept at WIDE_W bits.
module fx_mult
  import lorenz_pkg::*;
#(
  parameter int AW = WIDTH,
  parameter int BW = WIDTH
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [BW-1:0] b_i,
  output fx_wide_t             p_o
);
  logic signed [AW+BW-1:0] prod;

  assign prod = a_i * b_i;
  // Arithmetic shift floors toward -inf; upper bits beyond WIDE_W are sign copies in range.
  assign p_o  = fx_wide_t'(prod >>> FRAC);
endmodule

// File: rtl/lorenz_euler_integrator.sv
// Free-running explicit-Euler Lorenz integrator; one time step per rising clock edge.
module lorenz_euler_integrator
  import lorenz_pkg::*;
#(
  parameter fx_t SIGMA = lorenz_pkg::SIGMA,
  parameter fx_t RHO   = lorenz_pkg::RHO,
  parameter fx_t BETA  = lorenz_pkg::BETA,
  parameter fx_t X0    = lorenz_pkg::X0,
  parameter fx_t Y0    = lorenz_pkg::Y0,
  parameter fx_t Z0    = lorenz_pkg::Z0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic signed [WIDTH-1:0] outX,
  output logic signed [WIDTH-1:0] outY,
  output logic signed [WIDTH-1:0] outZ
);
  fx_t x_q, y_q, z_q;
  fx_t x_d, y_d, z_d;

  logic signed [WIDTH:0] diff_yx, diff_rz;
  fx_wide_t m_sig, m_xr, m_xy, m_bz;
  logic signed [SUM_W-1:0] dx_sum, dy_sum, dz_sum;

  assign diff_yx = (WIDTH+1)'(y_q) - (WIDTH+1)'(x_q);
  assign diff_rz = (WIDTH+1)'(RHO) - (WIDTH+1)'(z_q);

  fx_mult #(.AW(WIDTH+1), .BW(WIDTH)) u_mul_sig (.a_i(diff_yx), .b_i(SIGMA), .p_o(m_sig));
  fx_mult #(.AW(WIDTH), .BW(WIDTH+1)) u_mul_xr  (.a_i(x_q),     .b_i(diff_rz), .p_o(m_xr));
  fx_mult #(.AW(WIDTH), .BW(WIDTH))   u_mul_xy  (.a_i(x_q),     .b_i(y_q),     .p_o(m_xy));
  fx_mult #(.AW(WIDTH), .BW(WIDTH))   u_mul_bz  (.a_i(BETA),    .b_i(z_q),     .p_o(m_bz));

  assign dx_sum = SUM_W'(m_sig);
  assign dy_sum = SUM_W'(m_xr) - SUM_W'(y_q);
  assign dz_sum = SUM_W'(m_xy) - SUM_W'(m_bz);

  // All three updates use the old state; the state add wraps modulo 2^WIDTH.
  assign x_d = x_q + fx_t'(dx_sum >>> DT_SHIFT);
  assign y_d = y_q + fx_t'(dy_sum >>> DT_SHIFT);
  assign z_d = z_q + fx_t'(dz_sum >>> DT_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= X0;
      y_q <= Y0;
      z_q <= Z0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign outX = x_q;
  assign outY = y_q;
  assign outZ = z_q;
endmodule

// File: tb/tb_lorenz_euler_integrator.sv
// Randomised-reset bench comparing the integrator against a plain-arithmetic Euler model.
module tb_lorenz_euler_integrator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [26:0] out_x, out_y, out_z;
  logic signed [26:0] fp_x, fp_y, fp_z;

  int checks = 0;
  int errors = 0;
  longint mx, my, mz;
  bit saw_pos = 1'b0;
  bit saw_neg = 1'b0;

  localparam longint SIG_L = 10485760;
  localparam longint RHO_L = 29360128;
  localparam longint BET_L = 2796203;
  localparam longint IX    = -1048576;
  localparam longint IY    = 104858;
  localparam longint IZ    = 26214400;

  lorenz_euler_integrator dut (
    .clk (clk), .reset (reset), .outX (out_x), .outY (out_y), .outZ (out_z)
  );

  lorenz_euler_integrator #(.X0('0), .Y0('0), .Z0('0)) dut_fp (
    .clk (clk), .reset (reset), .outX (fp_x), .outY (fp_y), .outZ (fp_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint wrap27(input longint v);
    longint t;
    t = v & ((64'sd1 <<< 27) - 1);
    if (t >= (64'sd1 <<< 26)) t = t - (64'sd1 <<< 27);
    return t;
  endfunction

  task automatic model_reset();
    mx = IX; my = IY; mz = IZ;
  endtask

  // dx/dt = sigma(y-x), dy/dt = x(rho-z)-y, dz/dt = xy-beta*z; floor shifts, dt = 2^-8
  task automatic model_step();
    longint dx, dy, dz;
    dx = (SIG_L * (my - mx)) >>> 20;
    dy = ((mx * (RHO_L - mz)) >>> 20) - my;
    dz = ((mx * my) >>> 20) - ((BET_L * mz) >>> 20);
    mx = wrap27(mx + (dx >>> 8));
    my = wrap27(my + (dy >>> 8));
    mz = wrap27(mz + (dz >>> 8));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, out_x, mx);
    chk({tag, "_y"}, out_y, my);
    chk({tag, "_z"}, out_z, mz);
    chk({tag, "_fp"}, longint'(fp_x) | longint'(fp_y) | longint'(fp_z), 0);
  endtask

  task automatic run_step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_state("step");
    chk("bound_x", longint'(out_x < 27'sd31457280 && out_x > -27'sd31457280), 1);
    chk("bound_y", longint'(out_y < 27'sd31457280 && out_y > -27'sd31457280), 1);
    chk("bound_z", longint'(out_z < 27'sd62914560 && out_z > 27'sd0), 1);
    if (out_x > 0) saw_pos = 1'b1;
    if (out_x < 0) saw_neg = 1'b1;
  endtask

  task automatic check_first(input string tag);
    chk({tag, "_x"}, out_x, -1003520);
    chk({tag, "_y"}, out_y, 92160);
    chk({tag, "_z"}, out_z, 25940923);
  endtask

  // Drop reset between edges, confirm the immediate reload, hold, then release on a negedge.
  task automatic async_pulse();
    #($urandom_range(1, 3));
    reset = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      check_state("async_hold");
    end
    reset = 1'b1;
    run_step();
    check_first("restart");
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_state("rst_hold");
    end
    reset = 1'b1;
    run_step();
    check_first("first");
    repeat (999) run_step();
    async_pulse();
    for (int i = 0; i < 19000; i++) begin
      if ($urandom_range(0, 1999) == 0) async_pulse();
      else run_step();
    end
    chk("lobes", longint'(saw_pos && saw_neg), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
